// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl - instruction fetch controller.
// Owns the fetch PC, drives an asynchronous-read instruction memory every
// cycle and buffers fetched words in a QDEPTH-entry prefetch queue that
// drains to decode over a valid/ready handshake. Accepts redirects (flush and
// restart) and a halt level from execute.
// Optional build macro: IFETCH_PERF_EN adds the fetch/stall perf counters;
// without it both counter outputs are tied to zero.
module ifetch_ctrl #(
    parameter int          QDEPTH   = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [15:0] fetch_pc,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt
);

    localparam int               PTR_W      = $clog2(QDEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [15:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    logic [15:0]      r_q_pc    [QDEPTH];
    logic [15:0]      r_q_instr [QDEPTH];

    logic             w_fetch_en;
    logic             w_pop;
    logic             w_push;
`ifdef IFETCH_PERF_EN
    logic             w_stall;
`endif

    // Handshake and push qualification.
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push    = w_fetch_en && !redirect_valid
                       && ((r_count != FULL_COUNT) || w_pop);

    // Head presentation: zero when the queue is empty so stale or
    // uninitialised storage never shows on the outputs.
    assign out_pc    = out_valid ? r_q_pc[r_rd_ptr]    : 16'h0000;
    assign out_instr = out_valid ? r_q_instr[r_rd_ptr] : 16'h0000;

    // The memory address is the fetch PC itself, so reads take no wait cycles.
    assign imem_addr = r_fetch_pc;
    assign fetch_pc  = r_fetch_pc;

    // Next occupancy: redirect empties the queue, otherwise push/pop balance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_count_next = r_count;
        if (redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: redirect outranks halt, halt outranks normal flow.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = halt_req ? S_HALT : S_FETCH;
        end else if (halt_req) begin
            w_state_next = S_HALT;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if ((w_count_next == FULL_COUNT) && !w_pop) begin
                        w_state_next = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_HALT: begin
                    w_state_next = (w_count_next == FULL_COUNT) ? S_FULL : S_FETCH;
                end
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

    // FSM outputs: fetch enable, and the stall qualifier for the perf counter.
    always_comb begin
        w_fetch_en = (r_state != S_HALT);
`ifdef IFETCH_PERF_EN
        w_stall    = (r_state == S_FULL) && !w_pop;
`endif
    end

    // Fetch PC: redirect reloads, every push advances by one with 16-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 16'd1;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Queue storage: tail write of {pc, instruction} on every push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy gates the outputs, so contents are don't-care when empty.
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= imem_instr;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // Perf counters: words pushed and cycles spent full without a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign fetch_cnt = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction fetch controller that sequences the asynchronous-read instruction memory for the CPU core. It owns the fetch program counter, drives the memory address every cycle, and buffers fetched words in a small prefetch queue. Words leave through a valid/ready handshake to decode. It sits between the instruction memory and the decode stage, and it accepts branch/jump redirects and a halt request from the execute stage.

## Interface
- QDEPTH, 4, prefetch queue entries; power of 2, at least 2.
- RESET_PC, 16'h0000, fetch PC loaded on reset.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  16  word address to instruction memory; equals fetch_pc.
- imem_instr  in  16  combinational read data for imem_addr.
- redirect_valid  in  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  16  redirect target word address.
- halt_req  in  1  level signal: stop issuing new fetches while high.
- out_valid  out  1  the queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  16  head instruction word.
- out_pc  out  16  address of the head instruction.
- fetch_pc  out  16  next address to fetch.
- fetch_cnt  out  16  perf: words pushed.
- stall_cnt  out  16  perf: cycles the queue was full.

## Operation
- State machine with states FETCH, FULL and HALT. The reset state is FETCH.
- **Push condition:**
  - Push requires state ≠ HALT, no redirect_valid, and (count < QDEPTH or a pop in the same cycle).
  - A push writes {fetch_pc, imem_instr} at the tail and sets fetch_pc ← fetch_pc + 1.
  - The increment is a 16-bit add and wraps from 16'hFFFF to 16'h0000.
- **Pop:** occurs when out_valid && out_ready. The head advances.
- **count update:**
  - push only: count + 1.
  - pop only: count − 1.
  - both: count unchanged.
- **Transitions:**
  - FETCH→FULL when count reaches QDEPTH with no pop.
  - FULL→FETCH on a pop.
  - Any state→HALT when halt_req = 1.
  - HALT→FETCH when halt_req = 0 (FULL if count = QDEPTH).
- **HALT:** no pushes occur. The queue keeps draining to decode. fetch_pc holds.
- **Redirect (highest priority):**
  - The queue is cleared and fetch_pc ← redirect_pc.
  - No push occurs that cycle. The state goes to FETCH, or to HALT if halt_req = 1.
  - A pop handshake in the same cycle counts as completed; decode owns that word.
- Queue pointers are log2(QDEPTH)-bit and wrap naturally. count is log2(QDEPTH)+1 bits.
- imem_addr = fetch_pc combinationally, so a fetch takes no wait cycles.

## Timing
- **Reset values:**
  - fetch_pc = imem_addr = RESET_PC.
  - out_valid = 0, out_instr = 16'h0000, out_pc = 16'h0000.
  - count = 0, fetch_cnt = stall_cnt = 0, state FETCH.
- **Latency:** a word fetched at edge N is visible at the head (out_valid = 1) after edge N. From reset release, the first out_valid is after the first clk edge.
- **Throughput:** 1 word per cycle when out_ready is held at 1. A full queue with a simultaneous pop still pushes, so there is no bubble.
- **Redirect:** redirect pulse at edge N gives out_valid = 0 after N. The first word from redirect_pc is valid after N+1.
- **Handshake stability:** out_instr and out_pc are stable while out_valid = 1 and out_ready = 0.
- **Reset mid-operation:** all state returns to reset values immediately, independent of clk. Queue contents are discarded.

## Configuration
- IFETCH_PERF_EN defined:
  - fetch_cnt increments on every push.
  - stall_cnt increments on every cycle in FULL with no pop.
  - Both are 16-bit and wrap at 16'hFFFF→0. Both are cleared by rst.
- IFETCH_PERF_EN undefined: no counter logic is built, and fetch_cnt and stall_cnt are tied to 16'h0000.

## Test plan
- **Streaming:** memory holds addr+16'h1000, out_ready = 1 after reset → out_pc 0,1,2,… on consecutive cycles with out_instr 16'h1000,16'h1001,….
- **Backpressure:** out_ready = 0 for 10 cycles → exactly QDEPTH (4) pushes, then FULL, fetch_pc = 4 and stall_cnt = 6 (with IFETCH_PERF_EN). Releasing out_ready → pc 0..3 then 4 with no gap.
- **Redirect:** redirect_valid with redirect_pc = 16'h0080 while 3 entries are queued → queue empties, and one cycle later out_pc = 16'h0080 with out_instr = mem[8'h80].
- **Halt:** halt_req high for 6 cycles with 2 entries queued and out_ready = 1 → both drain, then out_valid = 0 and fetch_pc frozen. Deassert → fetch resumes at the frozen fetch_pc.
- **Wrap:** redirect to 16'hFFFE → out_pc sequence FFFE, FFFF, 0000, 0001.
- **Asynchronous reset:** assert rst between clock edges mid-stream → out_valid = 0 and fetch_pc = RESET_PC immediately, and counters read 0.
